// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth-table sweeper.
package truth_table_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest supported number of DUT inputs (64-entry truth table).
  localparam int MAX_N_IN = 6;

  // Width of the per-vector settle counter (SETTLE up to 15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/settle_timer.sv
// Per-vector settle counter: counts up to SETTLE, then flags expiry.
module settle_timer
  import truth_table_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expire
);

  logic [CNT_W-1:0] r_cnt;

  // Counter: clear wins over increment so a new vector always starts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire = (r_cnt == CNT_W'(SETTLE));

endmodule

// File: rtl/truth_table_checker.sv
// Truth-table sweeper: walks every input vector, samples dut_y after a
// settle delay, records the table and compares it with a latched mask.
module truth_table_checker
  import truth_table_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 dut_y,
  output logic [N_IN-1:0]      stim,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   captured,
  output logic                 fail_valid,
  output logic [N_IN-1:0]      first_fail
);

  localparam int NV = 2**N_IN;

  state_t            r_state;
  state_t            w_state_next;
  logic [N_IN-1:0]   r_idx;
  logic [NV-1:0]     r_exp;
  logic [NV-1:0]     r_captured;
  logic [NV-1:0]     w_cap_next;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_fail_valid;
  logic [N_IN-1:0]   r_first_fail;
  logic              w_accept;
  logic              w_expire;
  logic              w_sample;
  logic              w_last;
  logic              w_mismatch;

  // start is only honoured outside a sweep.
  assign w_accept   = start && (r_state != RUN);
  assign w_sample   = (r_state == RUN) && w_expire;
  assign w_last     = (r_idx == N_IN'(NV-1));
  assign w_mismatch = (dut_y != r_exp[r_idx]);

  settle_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_accept || w_sample),
    .i_inc   ((r_state == RUN) && !w_expire),
    .o_expire(w_expire)
  );

  // Captured table with the current sample merged in, so the final compare
  // includes the last vector.
  always_comb begin
    w_cap_next        = r_captured;
    w_cap_next[r_idx] = dut_y;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_sample && w_last) w_state_next = DONE;
      DONE:    if (start) w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Index, capture, compare and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx        <= '0;
      r_exp        <= '0;
      r_captured   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
    end else if (w_accept) begin
      r_idx        <= '0;
      r_exp        <= expected;
      r_captured   <= '0;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
    end else if (w_sample) begin
      r_captured <= w_cap_next;
      // Only the lowest mismatching vector is remembered.
      if (w_mismatch && !r_fail_valid) begin
        r_fail_valid <= 1'b1;
        r_first_fail <= r_idx;
      end
      if (w_last) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_pass <= (w_cap_next == r_exp);
      end else begin
        r_idx <= r_idx + N_IN'(1);
      end
    end
  end

  assign stim       = r_idx;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign captured   = r_captured;
  assign fail_valid = r_fail_valid;
  assign first_fail = r_first_fail;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker with N_IN = 3 and the Lab 4
// function Y = A'C' + AC + AB', at SETTLE = 2 and SETTLE = 0.
module tb_truth_table_checker;
  import truth_table_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] expected = 8'h00;
  logic       dut_y;
  logic [2:0] stim;
  logic       busy, done, pass, fail_valid;
  logic [7:0] captured;
  logic [2:0] first_fail;

  logic       start0 = 1'b0;
  logic [7:0] expected0 = 8'h00;
  logic       dut_y0;
  logic [2:0] stim0;
  logic       busy0, done0, pass0, fail_valid0;
  logic [7:0] captured0;
  logic [2:0] first_fail0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Reference combinational function: A = s[2], B = s[1], C = s[0].
  function automatic logic lab_fn(input logic [2:0] s);
    return (~s[2] & ~s[0]) | (s[2] & s[0]) | (s[2] & ~s[1]);
  endfunction

  assign dut_y  = lab_fn(stim);
  assign dut_y0 = lab_fn(stim0);

  truth_table_checker #(.N_IN(3), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected), .dut_y(dut_y),
    .stim(stim), .busy(busy), .done(done), .pass(pass), .captured(captured),
    .fail_valid(fail_valid), .first_fail(first_fail)
  );

  truth_table_checker #(.N_IN(3), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .expected(expected0), .dut_y(dut_y0),
    .stim(stim0), .busy(busy0), .done(done0), .pass(pass0), .captured(captured0),
    .fail_valid(fail_valid0), .first_fail(first_fail0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SETTLE=2 sweep. ff = expected first failing vector (-1 for none).
  // With pulses set, stray start pulses and an expected change hit mid-run.
  task automatic sweep(input logic [7:0] m, input int ff, input bit pulses);
    expected = m;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    chk("restart_captured_clear", captured, 0);
    for (int j = 0; j < 24; j++) begin
      chk($sformatf("stim_j%0d", j), stim, j / 3);
      chk($sformatf("busy_j%0d", j), busy, 1);
      chk($sformatf("done_j%0d", j), done, 0);
      chk($sformatf("fail_valid_j%0d", j), fail_valid, (ff >= 0 && j >= 3 * (ff + 1)));
      start = pulses && (j == 5 || j == 12);
      if (pulses && j == 8) expected = ~m;
      @(negedge clk);
    end
    start    = 1'b0;
    expected = m;
    chk("end_busy", busy, 0);
    chk("end_done", done, 1);
    chk("end_captured", captured, 8'hB5);
    chk("end_pass", pass, (ff < 0));
    chk("end_fail_valid", fail_valid, (ff >= 0));
    chk("end_first_fail", first_fail, (ff < 0) ? 0 : ff);
    chk("end_stim_hold", stim, 7);
    $display("sweep mask=%h captured=%h pass=%b fail_valid=%b first_fail=%0d",
             m, captured, pass, fail_valid, first_fail);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_captured", captured, 0);
    chk("rst_stim", stim, 0);
    chk("rst_state", dut.r_state, IDLE);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_autostart", busy, 0);

    // Matching mask, single mismatch at vector 0, mismatch at vector 7.
    sweep(8'hB5, -1, 1'b0);
    sweep(8'hB4, 0, 1'b0);
    sweep(8'h35, 7, 1'b0);

    // Asynchronous reset mid-sweep.
    expected = 8'hB5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_pass", pass, 0);
    chk("midrst_captured", captured, 0);
    chk("midrst_fail_valid", fail_valid, 0);
    chk("midrst_first_fail", first_fail, 0);
    chk("midrst_stim", stim, 0);
    chk("midrst_state", dut.r_state, IDLE);
    @(negedge clk);
    rst = 1'b0;
    $display("reset mid-sweep applied");
    sweep(8'hB5, -1, 1'b0);

    // Stray starts and an expected change during RUN, then restart from DONE.
    sweep(8'hB5, -1, 1'b1);
    sweep(8'hB5, -1, 1'b0);

    // SETTLE = 0: one vector per cycle.
    expected0 = 8'hB5;
    start0    = 1'b1;
    @(negedge clk);
    start0    = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("s0_stim_j%0d", j), stim0, j);
      chk($sformatf("s0_busy_j%0d", j), busy0, 1);
      @(negedge clk);
    end
    chk("s0_done", done0, 1);
    chk("s0_busy_end", busy0, 0);
    chk("s0_captured", captured0, 8'hB5);
    chk("s0_pass", pass0, 1);
    chk("s0_fail_valid", fail_valid0, 0);
    $display("sweep settle0 mask=%h captured=%h pass=%b", expected0, captured0, pass0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Self-checking truth-table sweeper for the Lab 4 combinational functions. It drives a combinational DUT through all 2^N_IN input combinations in ascending binary order and samples the DUT output after a programmable settle time. It records the captured truth table and compares it bit-for-bit against an expected mask. It sits between the board switch/LED glue and any gate-level or operator-level function, and reports pass/fail on the board LEDs.

## Interface
Parameters:
- N_IN, 4, number of DUT inputs; legal range 1..6; stim bit N_IN-1 is input A (MSB).
- SETTLE, 2, extra wait cycles per vector before sampling; legal range 0..15.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; honoured only in IDLE or DONE.
- expected  input  2**N_IN  golden truth table; bit i = required Y for stim == i; sampled once at start acceptance.
- dut_y  input  1  DUT output; treated as combinational from stim.
- stim  output  N_IN  DUT input vector.
- busy  output  1  high while sweeping.
- done  output  1  high from sweep completion until the next accepted start or reset.
- pass  output  1  valid when done; 1 means captured equals the latched expected mask.
- captured  output  2**N_IN  bit i = dut_y sampled for vector i.
- fail_valid  output  1  at least one mismatch has been seen in the current sweep.
- first_fail  output  N_IN  index of the lowest mismatching vector; 0 when fail_valid = 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE to RUN on start = 1. On that edge: idx = 0, stim = 0, cnt = 0, captured = 0, fail_valid = 0, first_fail = 0, pass = 0, done = 0, expected latched.
- RUN, each edge: if cnt < SETTLE then cnt++. Else (cnt == SETTLE):
  - captured[idx] = dut_y.
  - On mismatch with latched expected[idx] while fail_valid = 0, set fail_valid = 1 and first_fail = idx.
  - If idx == 2**N_IN-1, go to DONE. Otherwise idx++, stim = idx+1, cnt = 0.
- Entering DONE: done = 1, busy = 0, pass = (final captured == latched expected), so the last sample is included. stim holds the last vector.
- DONE to RUN on start, with the same initialisation as from IDLE.
- start in RUN is ignored. A change to the expected input during RUN has no effect.
- Width rules: idx and stim are N_IN bits. cnt is 4 bits. A mismatch test is done only on the sampling edge.

## Timing
- Reset values (asynchronous): state = IDLE, stim = 0, busy = 0, done = 0, pass = 0, captured = 0, fail_valid = 0, first_fail = 0, cnt = 0.
- Reset mid-sweep aborts immediately to IDLE with the values above. No partial result is retained.
- busy rises on the edge that accepts start.
- Each vector is held for exactly SETTLE+1 cycles. Vector i is sampled on edge k + (i+1)·(SETTLE+1), where k is the accepting edge.
- done and pass are valid after edge k + 2**N_IN·(SETTLE+1).
- SETTLE = 0 samples every cycle, with one full cycle for the DUT to settle after the stim change.
- start held high continuously in DONE restarts on the next edge. No automatic restart from IDLE occurs without start.

## Structure
- Shared package truth_table_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - constant MAX_N_IN = 6;
  - cnt width constant CNT_W = 4.
- One sub-module, settle_timer: holds cnt, takes load/clear, and outputs expire = (cnt == SETTLE).
- The FSM, index counter and capture/compare logic live in truth_table_checker.

## Test plan
Common setup for all scenarios: N_IN = 3, SETTLE = 2, DUT is Y = A'C' + AC + AB' (stim[2] = A, stim[0] = C).
- expected = 8'hB5, start pulse: busy for 24 cycles, then captured = 8'hB5, pass = 1, fail_valid = 0, first_fail = 0.
- expected = 8'hB4: captured = 8'hB5, pass = 0, fail_valid = 1, first_fail = 0. first_fail stays 0 even though no later mismatch occurs.
- expected = 8'h35: fail_valid rises on the sampling edge of vector 7 (edge k+24), first_fail = 7, pass = 0.
- Assert rst at cycle 10 of a sweep: all outputs are 0 within the same cycle and state = IDLE. A new start then yields 8'hB5 and pass = 1 after 24 cycles.
- start pulses at cycles 5 and 12 during RUN are ignored. Completion still occurs at cycle 24; then start in DONE clears done and captured and re-runs.
- Stim monitor: stim steps 0..7, each value held exactly 3 cycles. Repeat with SETTLE = 0: 8-cycle sweep, identical captured = 8'hB5.
